// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin share of the register-file write port plus a 16-address fill sequencer.
// Latency: an accepted request drives the rf write signals on the next edge; storage commits one edge later.
// Backpressure: req_ready grants one valid requester per cycle and stays low during a fill or on init_start.
// Build option: define REGFILE_ARB_HIPRI_EN to give requester 0 absolute priority over the round-robin group.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      init_start,
    input  logic [DATA_W-1:0]         init_value,
    output logic                      init_busy,
    output logic                      init_done,
    output logic                      rf_write_read_enable,
    output logic [ADDR_W-1:0]         rf_write_add,
    output logic [DATA_W-1:0]         rf_write_val
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ADDR_W-1:0]  fill_cnt, fill_cnt_nxt;
    logic [DATA_W-1:0]  fill_val, fill_val_nxt;
    logic               init_done_nxt;
    logic               we_n_nxt;
    logic [ADDR_W-1:0]  add_nxt;
    logic [DATA_W-1:0]  val_nxt;

    logic [NUM_REQ-1:0] rr_cand;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   scan_idx;
    int                 scan_sum;
    logic               accept;

    // Find the first candidate at or after rr_ptr (with wrap); requester 0 may bypass the rotation.
    always_comb begin
        rr_cand   = req_valid;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = 0;
        scan_idx  = '0;
`ifdef REGFILE_ARB_HIPRI_EN
        rr_cand[0] = 1'b0;
        if (req_valid[0]) begin
            grant_any = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NUM_REQ) begin
                scan_sum = scan_sum - NUM_REQ;
            end
            scan_idx = PTR_W'(scan_sum);
            if (!grant_any && rr_cand[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // One-hot grant, suppressed while filling and in the cycle a fill is requested.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !init_start && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept    = |req_ready;
    assign init_busy = (state == INIT);

    // Next-state and next register-file drive: fill writes in INIT, granted request writes in IDLE.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        fill_cnt_nxt  = fill_cnt;
        fill_val_nxt  = fill_val;
        init_done_nxt = 1'b0;
        we_n_nxt      = 1'b1;
        add_nxt       = rf_write_add;
        val_nxt       = rf_write_val;
        case (state)
            IDLE: begin
                if (init_start) begin
                    state_nxt    = INIT;
                    fill_cnt_nxt = '0;
                    fill_val_nxt = init_value;
                end else if (accept) begin
                    we_n_nxt = 1'b0;
                    add_nxt  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    val_nxt  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
`ifdef REGFILE_ARB_HIPRI_EN
                    if (grant_idx != '0) begin
                        rr_ptr_nxt = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    end
`else
                    rr_ptr_nxt = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
                end
            end
            INIT: begin
                we_n_nxt     = 1'b0;
                add_nxt      = fill_cnt;
                val_nxt      = fill_val;
                fill_cnt_nxt = fill_cnt + 1'b1;
                if (fill_cnt == LAST_ADDR) begin
                    state_nxt     = IDLE;
                    init_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset parks the write port in read/idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            fill_cnt             <= '0;
            fill_val             <= '0;
            init_done            <= 1'b0;
            rf_write_read_enable <= 1'b1;
            rf_write_add         <= '0;
            rf_write_val         <= '0;
        end else begin
            state                <= state_nxt;
            rr_ptr               <= rr_ptr_nxt;
            fill_cnt             <= fill_cnt_nxt;
            fill_val             <= fill_val_nxt;
            init_done            <= init_done_nxt;
            rf_write_read_enable <= we_n_nxt;
            rf_write_add         <= add_nxt;
            rf_write_val         <= val_nxt;
        end
    end

endmodule
